// File: rtl/tdm_pkg.sv
// Shared types and sizes for the 8-to-1 TDM transmit path.
package tdm_pkg;
    localparam int N_LANES = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    typedef logic [N_LANES-1:0] lane_mask_t;
endpackage

// File: rtl/tdm_mux_8to1_if.sv
// Frame-in / serial-out bundle of the TDM multiplexer.
interface tdm_mux_8to1_if;
    import tdm_pkg::*;

    lane_mask_t       in_data;
    lane_mask_t       lane_en;
    logic             in_valid;
    logic             in_ready;
    logic             out;
    logic [SEL_W-1:0] out_sel;
    logic             out_valid;
    logic             frame_start;

    modport master (
        output in_data, lane_en, in_valid,
        input  in_ready, out, out_sel, out_valid, frame_start
    );

    modport slave (
        input  in_data, lane_en, in_valid,
        output in_ready, out, out_sel, out_valid, frame_start
    );
endinterface

// File: rtl/tdm_mux_8to1_lane_pri_enc.sv
// Finds the lowest enabled lane strictly above cur (or from lane 0 when first).
module lane_pri_enc
    import tdm_pkg::*;
(
    input  lane_mask_t       mask,
    input  logic [SEL_W-1:0] cur,
    input  logic             first,
    output logic [SEL_W-1:0] idx,
    output logic             none_left
);
    // Scan downwards so the lowest qualifying lane is the last one written.
    always_comb begin
        idx       = '0;
        none_left = 1'b1;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (mask[i] && (first || i > int'(cur))) begin
                idx       = SEL_W'(i);
                none_left = 1'b0;
            end
        end
    end
endmodule

// File: rtl/tdm_mux_8to1.sv
// Serialises one 8-lane frame per handshake, one enabled lane per clock,
// tagging each bit with its lane index for the receiving demux.
module tdm_mux_8to1
    import tdm_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    tdm_mux_8to1_if.slave  bus
);
    state_t           state, state_n;
    lane_mask_t       sh_data, sh_data_n;
    lane_mask_t       sh_en, sh_en_n;
    logic             out_q, out_n;
    logic [SEL_W-1:0] sel_q, sel_n;
    logic             ov_q, ov_n;
    logic             fs_q, fs_n;

    logic [SEL_W-1:0] adv_idx, first_idx;
    logic             adv_none, first_none;
    logic             last, ready, accept;

    // The registered out_sel doubles as the current slot while in SEND.
    lane_pri_enc u_adv (
        .mask      (sh_en),
        .cur       (sel_q),
        .first     (1'b0),
        .idx       (adv_idx),
        .none_left (adv_none)
    );

    lane_pri_enc u_first (
        .mask      (bus.lane_en),
        .cur       ('0),
        .first     (1'b1),
        .idx       (first_idx),
        .none_left (first_none)
    );

    assign last   = (state == SEND) && adv_none;
    assign ready  = !rst && ((state == IDLE) || last);
    assign accept = bus.in_valid && ready;

    always_comb begin
        state_n   = IDLE;
        sh_data_n = sh_data;
        sh_en_n   = sh_en;
        out_n     = 1'b0;
        sel_n     = '0;
        ov_n      = 1'b0;
        fs_n      = 1'b0;
        if (accept) begin
            sh_data_n = bus.in_data;
            sh_en_n   = bus.lane_en;
            if (!first_none) begin
                state_n = SEND;
                out_n   = bus.in_data[first_idx];
                sel_n   = first_idx;
                ov_n    = 1'b1;
                fs_n    = 1'b1;
            end
        end else begin
            case (state)
                SEND: begin
                    if (!adv_none) begin
                        state_n = SEND;
                        out_n   = sh_data[adv_idx];
                        sel_n   = adv_idx;
                        ov_n    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sh_data <= '0;
            sh_en   <= '0;
            out_q   <= 1'b0;
            sel_q   <= '0;
            ov_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state   <= state_n;
            sh_data <= sh_data_n;
            sh_en   <= sh_en_n;
            out_q   <= out_n;
            sel_q   <= sel_n;
            ov_q    <= ov_n;
            fs_q    <= fs_n;
        end
    end

    assign bus.in_ready    = ready;
    assign bus.out         = out_q;
    assign bus.out_sel     = sel_q;
    assign bus.out_valid   = ov_q;
    assign bus.frame_start = fs_q;
endmodule

// File: doc/tdm_mux_8to1.md
# tdm_mux_8to1

Sequential 8-to-1 time-division multiplexer: the transmit end of the lane-select path whose receive end is `demux_1to8`. Accepts one 8-lane parallel frame through a valid/ready handshake and serialises it one lane per clock. Each output bit carries its lane index on `out_sel`, so `out`/`out_sel` feed `demux_1to8` `in`/`sel` directly. A per-frame lane-enable mask skips unused lanes.

## Interface
- `N_LANES`, 8: number of lanes; fixed at 8 for this revision.
- `SEL_W`, 3: lane index width, log2(`N_LANES`).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_data`  in  8  one bit per lane; bit i is lane i.
- `lane_en`  in  8  lane-enable mask, sampled with `in_data`.
- `in_valid`  in  1  frame offered.
- `in_ready`  out  1  block accepts a frame this cycle.
- `out`  out  1  serial data bit (to demux `in`).
- `out_sel`  out  3  lane index of `out` (to demux `sel`).
- `out_valid`  out  1  `out`/`out_sel` valid this cycle.
- `frame_start`  out  1  first valid slot of a frame.

## Operation
- Frame accepted on a rising edge where `in_valid && in_ready`. `in_data` and `lane_en` are captured into shadow registers on that edge; later input changes have no effect on the frame in flight.
- States:
  - IDLE: no frame in flight.
  - SEND: one enabled lane emitted per cycle.
- IDLE + accept with nonzero mask:
  - go to SEND.
  - Slot = lowest set bit of the mask.
- IDLE + accept with zero mask:
  - frame is consumed and discarded.
  - Stay in IDLE; no output.
- SEND, each cycle:
  - `out` = shadow_data[slot], `out_sel` = slot, `out_valid` = 1.
  - `frame_start` = 1 only on the first slot of the frame.
- Next slot = lowest enabled lane strictly above the current slot. Lanes are always ascending; there is no wrap to lane 0 within a frame.
- Last slot = no enabled lane above the current slot.
- Last slot, no accept: go to IDLE.
- Last slot, accept with nonzero mask: next cycle is the first slot of the new frame, with `frame_start` = 1 (back-to-back).
- Last slot, accept with zero mask: new frame is discarded; go to IDLE.
- `in_ready` = 1 in IDLE or on the last slot of SEND, else 0. It is combinational from registered state and is 0 while `rst` is high.

## Timing
- Reset values:
  - `out` = 0, `out_sel` = 0, `out_valid` = 0, `frame_start` = 0.
  - State = IDLE.
  - Shadow registers = 0.
- Reset asserted mid-frame aborts the frame immediately; no remaining slots are emitted.
- `out`, `out_sel`, `out_valid` and `frame_start` are registered.
- Latency: accept on edge N, first valid slot during cycle N+1.
- A frame with k enabled lanes occupies exactly k consecutive valid cycles.
- Full mask, back-to-back: 8 valid cycles per frame with no bubble (100% throughput).
- When `out_valid` = 0: `out` = 0, `out_sel` = 0, `frame_start` = 0.
- `in_valid` with `in_ready` = 0 is ignored. The producer must hold the frame until accepted.

## Structure
- Package `tdm_pkg` holds:
  - `N_LANES`, `SEL_W`
  - state enum (IDLE, SEND)
  - lane mask typedef (8-bit)
- Sub-module `lane_pri_enc`: combinational.
  - Inputs: mask, current slot, first flag.
  - Outputs: next enabled lane index and `none_left` flag.
  - Used both for the first-slot search (first flag set: search from bit 0) and for advancing.
- Top level holds the FSM, shadow registers and output registers.

## Test plan
- Reset mid-frame: assert `rst` during slot 3 of a full-mask frame -> all outputs 0 in the same cycle; after release, `in_ready` = 1 and no further slots.
- Full mask, single frame: `in_data` = 8'b1010_0110, `lane_en` = 8'hFF -> `out_sel` 0..7 on 8 consecutive cycles.
  - `out` = 0,1,1,0,0,1,0,1.
  - `frame_start` only on `out_sel` = 0.
  - `in_ready` high on slot 7 only.
- Sparse mask: `lane_en` = 8'b1001_0010, `in_data` = 8'hFF -> 3 valid cycles, `out_sel` = 1, 4, 7, all `out` = 1; `out_valid` drops after.
- Back-to-back: frame A (8'hF0, mask 8'hFF) with frame B (8'h0F, mask 8'h81) held valid -> B accepted on A's slot-7 edge.
  - Next cycle: `out_sel` = 0, `out` = 1, `frame_start` = 1.
  - Then `out_sel` = 7, `out` = 0.
  - Zero-cycle gap between frames.
- Zero mask: `lane_en` = 0, `in_valid` = 1 -> accepted, no `out_valid` pulse; a following frame is accepted on the next cycle.
- Loopback: connect `out`/`out_sel` to a `demux_1to8` and register its lanes on `out_valid` -> reconstructed byte equals `in_data` for 8'h00, 8'hFF, 8'h5A and 8'hA5.
